// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       write_enb,
  input  logic                       read,
  input  logic                       flush,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_THR = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [CW-1:0]         count_nxt_s;

  // Acceptance decisions and next occupancy; flush overrides both requests.
  always_comb begin
    rd_acc_s    = 1'b0;
    wr_acc_s    = 1'b0;
    count_nxt_s = count;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      rd_acc_s = read & ~empty;
      // A full FIFO still takes a write when a read frees a slot on the same edge.
      wr_acc_s = write_enb & (~full | rd_acc_s);
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_nxt_s = count + ONE_C;
        2'b01:   count_nxt_s = count - ONE_C;
        default: count_nxt_s = count;
      endcase
    end
  end

  // Storage array: written only on accepted writes, never reset.
  always_ff @(posedge clock) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, read data, occupancy and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      data_out     <= {DATA_WIDTH{1'b0}};
      count        <= {CW{1'b0}};
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (rd_acc_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
          data_out <= mem_r[rd_ptr_r];
        end
      end
      count        <= count_nxt_s;
      full         <= (count_nxt_s == CW'(DEPTH));
      empty        <= (count_nxt_s == {CW{1'b0}});
      almost_full  <= (count_nxt_s >= AF_THR);
      almost_empty <= (count_nxt_s <= AE_THR);
      overflow     <= write_enb & ~flush & ~wr_acc_s;
      underflow    <= read & ~flush & empty;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: a queue-based reference model predicts each
// cycle's outputs, and a negedge monitor pops and compares them.
module tb_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clock;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          write_enb;
  logic          read;
  logic          flush;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  fifo_param dut (
    .clock(clock), .reset(reset), .data_in(data_in), .write_enb(write_enb),
    .read(read), .flush(flush), .data_out(data_out), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int dout;
    int cnt;
    int full;
    int empty;
    int af;
    int ae;
    int ovf;
    int unf;
  } exp_t;

  exp_t exp_q[$];
  int   model_q[$];
  int   model_dout;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Reference model: one call per clock edge, predicting outputs after it.
  task automatic step(input bit w, input bit r, input bit f, input bit rs, input int d);
    exp_t e;
    int   ovf = 0;
    int   unf = 0;
    write_enb = w;
    read      = r;
    flush     = f;
    reset     = rs;
    data_in   = d[DW-1:0];
    if (rs) begin
      model_q.delete();
      model_dout = 0;
    end else if (f) begin
      model_q.delete();
    end else begin
      bit was_empty = (model_q.size() == 0);
      bit was_full  = (model_q.size() == DEPTH);
      bit rd_ok     = r && !was_empty;
      bit wr_ok     = w && (!was_full || rd_ok);
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(d & 8'hFF);
      ovf = (w && !wr_ok) ? 1 : 0;
      unf = (r && was_empty) ? 1 : 0;
    end
    e.dout  = model_dout;
    e.cnt   = model_q.size();
    e.full  = (model_q.size() == DEPTH) ? 1 : 0;
    e.empty = (model_q.size() == 0) ? 1 : 0;
    e.af    = (model_q.size() >= AF) ? 1 : 0;
    e.ae    = (model_q.size() <= AE) ? 1 : 0;
    e.ovf   = ovf;
    e.unf   = unf;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: the DUT presents a fresh set of outputs after every edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("data_out",     int'(data_out),     e.dout);
      chk("count",        int'(count),        e.cnt);
      chk("full",         int'(full),         e.full);
      chk("empty",        int'(empty),        e.empty);
      chk("almost_full",  int'(almost_full),  e.af);
      chk("almost_empty", int'(almost_empty), e.ae);
      chk("overflow",     int'(overflow),     e.ovf);
      chk("underflow",    int'(underflow),    e.unf);
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_dout = 0;
    reset = 1'b1; write_enb = 1'b0; read = 1'b0; flush = 1'b0; data_in = '0;

    // Reset, fill with 0x01..0x10, then one write too many.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, i);
    step(1, 0, 0, 0, 8'h11);
    step(0, 0, 0, 0, 0);
    // Drain in order, then one read too many.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Simultaneous read/write while full.
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, i);
    step(1, 1, 0, 0, 8'hAA);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0);
    // Pointer wrap: 10 in, 10 out, twice.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'h20 + 16 * k + i);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    end
    // Flush with both requests asserted, then a fresh write/read.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'h60 + i);
    step(1, 1, 1, 0, 8'h77);
    step(1, 0, 0, 0, 8'h55);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Reset mid-operation with a write pending.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'h80 + i);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 8'hEE);
    step(1, 0, 0, 0, 8'h33);
    step(0, 1, 0, 0, 0);

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 2000; i++) begin
      int wp = ((i / 150) % 2 == 0) ? 75 : 30;
      bit w  = ($urandom_range(0, 99) < wp);
      bit r  = ($urandom_range(0, 99) < (100 - wp));
      bit f  = ($urandom_range(0, 59) == 0);
      bit rs = ($urandom_range(0, 399) == 0);
      step(w, r, f, rs, int'($urandom_range(0, 255)));
    end
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage words; power of 2, >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold in words (1..DEPTH-1).
REQ-005 clock  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  DATA_WIDTH  write data.
REQ-008 write_enb  input  1  write request.
REQ-009 read  input  1  read request.
REQ-010 flush  input  1  synchronous clear of contents.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_LEVEL.
REQ-015 almost_empty  output  1  count <= AE_LEVEL.
REQ-016 count  output  log2(DEPTH)+1  current occupancy.
REQ-017 overflow  output  1  one-cycle pulse: write rejected.
REQ-018 underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 Write accepted when write_enb=1, flush=0, and (full=0 or read accepted same cycle); data_in stored at write pointer, pointer increments modulo DEPTH.
REQ-020 Read accepted when read=1, flush=0, empty=0; word at read pointer loaded into data_out on that edge, pointer increments modulo DEPTH.
REQ-021 Read latency: data_out valid the cycle after the edge where read is accepted; otherwise data_out holds its last value.
REQ-022 Read and write accepted together: count unchanged; when empty=1 the read is rejected and only the write is accepted.
REQ-023 count +1 on accepted write only, -1 on accepted read only, unchanged otherwise; never exceeds DEPTH nor goes below 0.
REQ-024 full, empty, almost_full, almost_empty all registered and consistent with count in the same cycle.
REQ-025 overflow=1 for one cycle after an edge with write_enb=1, flush=0, write rejected; storage, pointers, count unchanged.
REQ-026 underflow=1 for one cycle after an edge with read=1, flush=0, empty=1; data_out unchanged.
REQ-027 Pointers wrap DEPTH-1 -> 0 with no bubble; FIFO order preserved across wrap.
REQ-028 flush=1: pointers and count cleared to 0, empty=1, full=0, almost_empty=1, almost_full=0 next cycle; write and read ignored; no overflow/underflow; data_out holds.
REQ-029 Storage contents need no reset; data read only from written locations.

Reset
REQ-030 reset=1 at a rising edge: data_out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, pointers=0.
REQ-031 reset has priority over flush, write_enb and read; asserted mid-operation it discards all contents and pending requests.
REQ-032 First write is accepted on the first edge with reset=0.

Verification
REQ-033 Defaults; reset, write 0x01..0x10 (16 words) -> full=1 and count=16 after 16th; almost_full=1 from count=14; 17th write -> overflow pulse, count stays 16.
REQ-034 Read 16 times -> data_out 0x01..0x10 in order, each one cycle after read; empty=1 after last; extra read -> underflow pulse, data_out stays 0x10.
REQ-035 Fill to 16, assert write_enb and read together with data_in=0xAA -> data_out=0x01, count stays 16, no overflow; 0xAA later emerges as 16th read.
REQ-036 Write 10, read 10, write 10, read 10 -> pointers wrap; outputs match write order; count returns to 0.
REQ-037 Write 5, flush with write_enb=1 and read=1 -> count=0, empty=1, no flags; next write 0x55, read -> data_out=0x55.
REQ-038 Write 8, assert reset with write_enb=1 -> all outputs at REQ-030 values next cycle; count=0.
